// File: rtl/score_display_pkg.sv
// Shared constants for the score display path: widths, converter FSM
// encoding, 7-segment codes and the double-dabble adjust step.
package score_display_pkg;

  localparam int SCORE_W    = 14;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Converter FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  // Add 3 to every BCD nibble that is >= 5, ahead of the left shift
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int k = 0; k < BCD_DIGITS; k++) begin
      if (bcd[k*4 +: 4] >= 4'd5) res[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit per clock, SCORE_W shift cycles
// followed by a single commit cycle that pulses done_o.
module bin2bcd_seq
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] bin_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [BCD_W-1:0]   bcd_o
);

  logic [1:0]         state_q, state_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_adj;

  assign bcd_adj = dabble_adjust(bcd_q);

  // Next-state logic for the IDLE -> SHIFT x14 -> COMMIT sequence
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[SCORE_W-1]};
        bin_d = {bin_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(SCORE_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      // NOTE: the shift/BCD registers are plain flops, not memory, so resetting them is cheap and keeps sim free of X.
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_COMMIT);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_display.sv
// Score display top: selects score or high score, clamps, converts to BCD
// when the value changes, and multiplexes four active-low 7-segment digits.
module score_display
  import score_display_pkg::*;
#(
  parameter int REFRESH_BITS  = 18,
  parameter int BLANK_LEADING = 1,
  parameter int CLAMP_MAX     = 9999
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SCORE_W-1:0] score,
  input  logic [SCORE_W-1:0] high_score,
  input  logic               show_high,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic               dp,
  output logic               busy
);

  localparam logic [SCORE_W-1:0] CLAMP_V = SCORE_W'(CLAMP_MAX);

  logic [SCORE_W-1:0]      val_c, clamped_c;
  logic [SCORE_W-1:0]      last_q;
  logic                    valid_q;
  logic [BCD_W-1:0]        digits_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              an_q, an_d;
  logic                    start_c, conv_busy, conv_done;
  logic [BCD_W-1:0]        conv_bcd;
  logic [1:0]              idx;
  logic [3:0]              cur_digit;
  logic [3:0]              blank_vec;

  assign val_c     = show_high ? high_score : score;
  assign clamped_c = (val_c > CLAMP_V) ? CLAMP_V : val_c;

  // A conversion starts in IDLE when nothing valid is shown or the value moved
  assign start_c = !conv_busy && (!valid_q || (clamped_c != last_q));

  bin2bcd_seq u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start_c),
    .bin_i   (clamped_c),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  // Capture the compared value on start, commit the digits on done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= '0;
      valid_q  <= 1'b0;
      digits_q <= '0;
    end else begin
      if (start_c) last_q <= clamped_c;
      if (conv_done) begin
        digits_q <= conv_bcd;
        valid_q  <= 1'b1;
      end
    end
  end

  // Free-running refresh counter; its top two bits pick the active digit
  always_ff @(posedge clk) begin
    if (!rst_n) refresh_q <= '0;
    else        refresh_q <= refresh_q + 1'b1;
  end

  assign idx       = refresh_q[REFRESH_BITS-1 -: 2];
  assign cur_digit = digits_q[{idx, 2'b00} +: 4];

  // Leading-zero blanking: a digit blanks when it and everything above it are zero
  always_comb begin
    blank_vec    = 4'b0000;
    blank_vec[3] = (digits_q[15:12] == 4'd0);
    blank_vec[2] = blank_vec[3] && (digits_q[11:8] == 4'd0);
    blank_vec[1] = blank_vec[2] && (digits_q[7:4] == 4'd0);
    if (BLANK_LEADING == 0) blank_vec = 4'b0000;
  end

  // Anode/segment pattern for the currently selected digit
  always_comb begin
    an_d  = ~(4'b0001 << idx);
    seg_d = seg_encode(cur_digit);
    if (blank_vec[idx]) begin
      an_d  = 4'hF;
      seg_d = SEG_BLANK;
    end
  end

  // Registered display drive so the pins change cleanly one clock after idx
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;
  assign busy = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short refresh counter (4 clk per digit).
module tb_score_display;

  logic        clk;
  logic        rst_n;
  logic [13:0] score;
  logic [13:0] high_score;
  logic        show_high;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  score_display #(.REFRESH_BITS(4), .BLANK_LEADING(1), .CLAMP_MAX(9999)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score      (score),
    .high_score (high_score),
    .show_high  (show_high),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Count consecutive negedge samples with busy high (bounded)
  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Observe 16 samples (one full refresh period) and record each digit's segments
  task automatic scan(output logic [27:0] segs, output logic [3:0] seen,
                      output bit bad, output int bcnt);
    int k;
    segs = '1;
    seen = '0;
    bad  = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 16; i++) begin
      k = -1;
      case (an)
        4'b1110: k = 0;
        4'b1101: k = 1;
        4'b1011: k = 2;
        4'b0111: k = 3;
        4'b1111: if (seg !== 7'h7F) bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (k >= 0) begin
        if (seen[k] && segs[k*7 +: 7] !== seg) bad = 1'b1;
        segs[k*7 +: 7] = seg;
        seen[k] = 1'b1;
      end
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    rst_n = 1'b0; score = '0; high_score = '0; show_high = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    tests_run++; if (an !== 4'hF) begin tests_failed++; $display("FAIL reset_an: got %h expected f", an); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp: got %b expected 1", dp); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_first_conv: busy=%b expected 1", busy); end
    measure_busy(n);
    tests_run++; if (n != 15) begin tests_failed++; $display("FAIL reset_busy_len: got %0d expected 15", n); end
    @(negedge clk);
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin tests_failed++; $display("FAIL reset_zero_segs: got %h expected %h", s, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    tests_run++; if (m !== 4'b0001) begin tests_failed++; $display("FAIL reset_zero_anodes: got %b expected 0001", m); end
    tests_run++; if (bad) begin tests_failed++; $display("FAIL reset_zero_pattern: got bad=1 expected 0"); end
  endtask

  task automatic test_basic();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    score = 14'd1234; show_high = 1'b0;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    measure_busy(n);
    tests_run++; if (n != 15) begin tests_failed++; $display("FAIL basic_busy_len: got %0d expected 15", n); end
    @(negedge clk);
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h79, 7'h24, 7'h30, 7'h19}) begin tests_failed++; $display("FAIL basic_1234_segs: got %h expected %h", s, {7'h79, 7'h24, 7'h30, 7'h19}); end
    tests_run++; if (m !== 4'b1111) begin tests_failed++; $display("FAIL basic_1234_anodes: got %b expected 1111", m); end
    tests_run++; if (bad || bc != 0) begin tests_failed++; $display("FAIL basic_1234_stable: got bad=%0d busy_cycles=%0d expected 0/0", bad, bc); end
  endtask

  task automatic test_clamp();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    score = 14'd16383;
    @(negedge clk);
    measure_busy(n);
    tests_run++; if (n != 15) begin tests_failed++; $display("FAIL clamp_busy_len: got %0d expected 15", n); end
    @(negedge clk);
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h10, 7'h10, 7'h10, 7'h10} || m !== 4'b1111) begin tests_failed++; $display("FAIL clamp_9999: got segs=%h anodes=%b expected %h/1111", s, m, {7'h10, 7'h10, 7'h10, 7'h10}); end
    // 10000 clamps to the same 9999 already shown: no new conversion
    score = 14'd10000;
    scan(s, m, bad, bc);
    tests_run++; if (bc != 0) begin tests_failed++; $display("FAIL clamp_no_reconv: got busy_cycles=%0d expected 0", bc); end
    tests_run++; if (s !== {7'h10, 7'h10, 7'h10, 7'h10} || bad) begin tests_failed++; $display("FAIL clamp_hold: got segs=%h bad=%0d expected %h/0", s, bad, {7'h10, 7'h10, 7'h10, 7'h10}); end
  endtask

  task automatic test_toggle();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    score = 14'd5; high_score = 14'd9870; show_high = 1'b0;
    @(negedge clk);
    measure_busy(n);
    @(negedge clk);
    show_high = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL toggle_busy_rise: got %b expected 1", busy); end
    measure_busy(n);
    tests_run++; if (n + 1 > 17 || n != 15) begin tests_failed++; $display("FAIL toggle_latency: got busy_len=%0d expected 15", n); end
    @(negedge clk);
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h10, 7'h00, 7'h78, 7'h40} || m !== 4'b1111) begin tests_failed++; $display("FAIL toggle_9870: got segs=%h anodes=%b expected %h/1111", s, m, {7'h10, 7'h00, 7'h78, 7'h40}); end
  endtask

  task automatic test_back_to_back();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    show_high = 1'b0; score = 14'd100;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy_rise: got %b expected 1", busy); end
    repeat (5) @(negedge clk);
    score = 14'd200;
    measure_busy(n);
    tests_run++; if (n != 10) begin tests_failed++; $display("FAIL b2b_first_len: got %0d expected 10", n); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_rise: got %b expected 1", busy); end
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h7F, 7'h79, 7'h40, 7'h40} || m !== 4'b0111) begin tests_failed++; $display("FAIL b2b_100: got segs=%h anodes=%b expected %h/0111", s, m, {7'h7F, 7'h79, 7'h40, 7'h40}); end
    tests_run++; if (bc != 15) begin tests_failed++; $display("FAIL b2b_second_len: got %0d expected 15", bc); end
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h7F, 7'h24, 7'h40, 7'h40} || m !== 4'b0111 || bad) begin tests_failed++; $display("FAIL b2b_200: got segs=%h anodes=%b bad=%0d expected %h/0111/0", s, m, bad, {7'h7F, 7'h24, 7'h40, 7'h40}); end
  endtask

  task automatic test_reset_mid();
    int n; logic [27:0] s; logic [3:0] m; bit bad; int bc;
    score = 14'd4321;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (seg !== 7'h7F || an !== 4'hF || busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_outputs: got seg=%h an=%h busy=%b expected 7f/f/0", seg, an, busy); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_restart: got %b expected 1", busy); end
    measure_busy(n);
    tests_run++; if (n != 15) begin tests_failed++; $display("FAIL midreset_busy_len: got %0d expected 15", n); end
    @(negedge clk);
    scan(s, m, bad, bc);
    tests_run++; if (s !== {7'h19, 7'h30, 7'h24, 7'h79} || m !== 4'b1111 || bad) begin tests_failed++; $display("FAIL midreset_4321: got segs=%h anodes=%b bad=%0d expected %h/1111/0", s, m, bad, {7'h19, 7'h30, 7'h24, 7'h79}); end
  endtask

  initial begin
    rst_n = 1'b0; score = '0; high_score = '0; show_high = 1'b0;
    test_reset();
    test_basic();
    test_clamp();
    test_toggle();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Consumer end of the score path. Takes the live 14-bit game score and the tracked 14-bit high score, selects one, and converts it to 4 BCD digits with a sequential double-dabble.
- Drives the board's 4-digit multiplexed 7-segment display. Segments and anodes are active-low.
- Sits between the score/high-score logic and the top-level display pins.

Parameters:
- REFRESH_BITS, 18, width of the free-running refresh counter. Top 2 bits select the digit; 2^16 clk per digit.
- BLANK_LEADING, 1, when 1, leading zero digits are blanked. Digit 0 is never blanked.
- CLAMP_MAX, 9999, selected values above this are displayed as CLAMP_MAX.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- score  in  14  current game score, binary
- high_score  in  14  tracked high score, binary
- show_high  in  1  1 = display high_score, 0 = display score
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- an  out  4  digit anodes, active-low; an[0] = ones digit
- dp  out  1  decimal point, active-low; held 1 (off)
- busy  out  1  conversion in progress

Behaviour:
- Reset (rst_n=0 sampled on a clk edge): seg=7'h7F, an=4'hF, dp=1, busy=0.
  - Digit registers cleared to 0.
  - Refresh counter cleared to 0.
  - FSM goes to IDLE.
  - Valid flag cleared, which forces a conversion on the first IDLE cycle after reset.
  - Reset mid-conversion aborts the conversion; the partial result is discarded.
- Selected value: val = show_high ? high_score : score. Clamped to CLAMP_MAX before capture.
- FSM:
  - IDLE: if !valid or clamp(val) != last_val, capture clamp(val) into the shift register and last_val, clear the BCD accumulator, set busy=1, go to SHIFT.
  - SHIFT: 14 cycles, one bit per cycle. Each cycle, add 3 to every BCD nibble that is >= 5, then shift left by 1 with the binary MSB entering the BCD LSB.
  - COMMIT: 1 cycle. Copy the 16-bit BCD result to the display digit registers, set valid=1, set busy=0, go to IDLE.
- Latency: a change on val is visible in the digit registers 16 clk after the IDLE cycle that samples it (capture + 14 shifts + commit).
- Input changes during SHIFT or COMMIT are ignored. They are compared again in the next IDLE and trigger a new conversion. No value is queued; only the latest val is taken.
- show_high toggling is treated like any other change in val.
- Multiplexing:
  - Refresh counter increments every clk and wraps at 2^REFRESH_BITS.
  - idx = counter[MSB:MSB-1].
  - an and seg are registered, updating 1 clk after idx changes.
  - an = ~(1<<idx), except for a blanked digit, where an=4'hF and seg=7'h7F.
- Blanking (BLANK_LEADING=1): digit k (k=3..1) is blanked when it and all digits above it are 0.
- Segment codes: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex). Nibble values >9 cannot occur.
- Display keeps showing the previous committed value while busy=1.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE, SHIFT, COMMIT).
  - 7-segment code constants for 0–9 and blank.
  - SCORE_W=14 and BCD_DIGITS=4.
- Sub-module bin2bcd_seq contains:
  - The double-dabble register, a 4-bit iteration counter, and start/done handshake.
  - start is accepted only when not busy; done is a 1-cycle pulse with bcd[15:0] valid.
- score_display contains the compare/capture logic, the clamp, the refresh counter and the anode/segment mux.

Test Plan (bench sets REFRESH_BITS=4, so each digit is shown for 4 clk):
- Reset held 3 clk with score=0: seg=7F, an=F, busy=0. After release, busy rises within 1 clk and falls 15 clk later. Afterwards only an=1110 is ever driven, with seg=40; no other anode goes low.
- score=1234, show_high=0: after busy falls, an cycles 1110/1101/1011/0111 with seg 19/30/24/79 (digits 4, 3, 2, 1).
- score=16383: display shows 9999, i.e. seg=10 on all four anodes.
- score=5, high_score=9870, toggle show_high 0→1: within 17 clk, digits read 9,8,7,0 (seg 10/00/78/40).
- score=100, then score=200 on the 5th SHIFT cycle: commits 100 first (digits 1,0,0, top digit blanked), then busy rises again on the next IDLE and 200 commits 16 clk later.
- rst_n=0 for 1 clk mid-SHIFT: next cycle seg=7F, an=F, busy=0. After release, the current val is converted from scratch.
